// File: rtl/dt_node_walker_pkg.sv
// Shared types and constants for the decision-tree node walker.
//   N         feature / threshold width
//   C         class width
//   F         number of features in a sample
//   NODES     node-table depth
//   MAX_STEPS maximum internal nodes visited before the walk is abandoned
//   node_t    one table word {leaf, feat, thr, left, right}
//   state_t   walker FSM states
package dt_walker_pkg;

   localparam int N         = 8;
   localparam int C         = 2;
   localparam int F         = 4;
   localparam int NODES     = 16;
   localparam int MAX_STEPS = NODES;

   localparam int AW     = $clog2(NODES);
   localparam int FW     = $clog2(F);
   localparam int NODE_W = 1 + FW + N + 2 * AW;
   localparam int STEP_W = $clog2(MAX_STEPS + 1);

   typedef struct packed {
      logic          leaf;
      logic [FW-1:0] feat;
      logic [N-1:0]  thr;
      logic [AW-1:0] left;
      logic [AW-1:0] right;
   } node_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WALK = 2'd1,
      DONE = 2'd2
   } state_t;

   // Leaf of class 0: an empty table classifies everything as class 0.
   localparam node_t RESET_NODE = 19'h40000;

   // Feature idx of a packed sample; index 0 sits in the LSBs.
   function automatic logic [N-1:0] feat_sel(input logic [F*N-1:0] v,
                                             input logic [FW-1:0]  idx);
      return v[idx*N +: N];
   endfunction

endpackage

// File: rtl/dt_node_walker_if.sv
// Handshake bundle of the node walker.
//   cfg_*   node-table write port (cfg_ready high only while idle)
//   in_*    sample input, valid/ready
//   out_*   result output, valid/ready, with cls and err
// master: the environment driving samples/config; slave: the walker.
interface dt_node_walker_if import dt_walker_pkg::*; ;

   logic              cfg_we;
   logic [AW-1:0]     cfg_addr;
   logic [NODE_W-1:0] cfg_data;
   logic              cfg_ready;
   logic              in_valid;
   logic              in_ready;
   logic [F*N-1:0]    in_feat;
   logic              out_valid;
   logic              out_ready;
   logic [C-1:0]      cls;
   logic              err;

   modport master (
      output cfg_we, cfg_addr, cfg_data, in_valid, in_feat, out_ready,
      input  cfg_ready, in_ready, out_valid, cls, err
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_data, in_valid, in_feat, out_ready,
      output cfg_ready, in_ready, out_valid, cls, err
   );

endinterface

// File: rtl/dt_node_table.sv
// NODES x node_t register file holding the decision tree.
//   clk, rst  clock and synchronous active-high reset (all words -> RESET_NODE)
//   we_i      write enable, waddr_i / wdata_i write port
//   raddr_i   combinational read address, rdata_o read data
module dt_node_table import dt_walker_pkg::*; (
   input  logic          clk,
   input  logic          rst,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  node_t         wdata_i,
   input  logic [AW-1:0] raddr_i,
   output node_t         rdata_o
);

   node_t mem_q [NODES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NODES; i++) begin
            mem_q[i] <= RESET_NODE;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dt_node_walker.sv
// Decision-tree classifier: accepts one feature sample, walks the node table
// one node per cycle from node 0 until a leaf gives the class, then holds the
// result until it is taken.  A walk longer than MAX_STEPS internal nodes ends
// with err = 1 and class 0.
//   clk  single clock
//   rst  synchronous active-high reset; aborts any walk and clears the table
//   bus  dt_node_walker_if slave (config, sample and result handshakes)
module dt_node_walker import dt_walker_pkg::*; (
   input logic              clk,
   input logic              rst,
   dt_node_walker_if.slave  bus
);

   state_t             state_q, state_d;
   logic [AW-1:0]      ptr_q, ptr_d;
   logic [STEP_W-1:0]  steps_q, steps_d;
   logic [C-1:0]       cls_q, cls_d;
   logic               err_q, err_d;
   logic [F*N-1:0]     feat_q;
   logic               feat_load;
   logic               idle;
   node_t              node;

   assign idle = (state_q == IDLE);

   // Writes are only honoured while idle so an in-flight walk sees a frozen
   // table; a write on the acceptance edge is visible to the walk.
   dt_node_table u_table (
      .clk     (clk),
      .rst     (rst),
      .we_i    (bus.cfg_we && idle),
      .waddr_i (bus.cfg_addr),
      .wdata_i (node_t'(bus.cfg_data)),
      .raddr_i (ptr_q),
      .rdata_o (node)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      steps_d   = steps_q;
      cls_d     = cls_q;
      err_d     = err_q;
      feat_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               feat_load = 1'b1;
               ptr_d     = '0;
               steps_d   = '0;
               state_d   = WALK;
            end
         end
         WALK: begin
            // The guard is checked before the node so a looping table
            // terminates after exactly MAX_STEPS internal visits.
            if (steps_q == STEP_W'(MAX_STEPS)) begin
               cls_d   = '0;
               err_d   = 1'b1;
               state_d = DONE;
            end else if (node.leaf) begin
               cls_d   = node.thr[C-1:0];
               err_d   = 1'b0;
               state_d = DONE;
            end else begin
               steps_d = steps_q + 1'b1;
               ptr_d   = (feat_sel(feat_q, node.feat) < node.thr) ? node.left
                                                                   : node.right;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         steps_q <= '0;
         cls_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         steps_q <= steps_d;
         cls_q   <= cls_d;
         err_q   <= err_d;
      end
   end

   // Sample is captured on acceptance so later in_feat changes are ignored.
   always_ff @(posedge clk) begin
      if (feat_load) begin
         feat_q <= bus.in_feat;
      end
   end

   assign bus.cfg_ready = idle;
   assign bus.in_ready  = idle;
   assign bus.out_valid = (state_q == DONE);
   assign bus.cls       = cls_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_dt_node_walker.sv
module tb_dt_node_walker;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   dt_node_walker_if bus ();

   dt_node_walker dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   localparam int MAXS = 16;
   logic [18:0] model_tbl [16];

   typedef struct {
      string       name;
      logic [31:0] feat;
      int          cls;
      int          err;
      int          lat;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [18:0] mk(input int leaf, input int feat, input int thr,
                                      input int l, input int r);
      return {1'(leaf), 2'(feat), 8'(thr), 4'(l), 4'(r)};
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) model_tbl[i] = 19'h40000;
   endfunction

   // Walk the tree as written in the table; latency counts the acceptance
   // edge as 0 and reports the edge at which out_valid is first seen high.
   function automatic void model_walk(input logic [31:0] f, output int c,
                                      output int e, output int lat);
      int p = 0;
      int visited = 0;
      logic [18:0] w;
      logic [7:0]  fv;
      c = 0;
      e = 0;
      while (1) begin
         if (visited == MAXS) begin
            c = 0;
            e = 1;
            break;
         end
         w = model_tbl[p];
         if (w[18]) begin
            c = int'(w[9:8]);
            break;
         end
         fv = 8'(f >> (32'(w[17:16]) * 8));
         p  = (fv < w[15:8]) ? int'(w[7:4]) : int'(w[3:0]);
         visited++;
      end
      lat = visited + 2;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      model_reset();
   endtask

   task automatic cfg_write(input int a, input logic [18:0] d);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 4'(a);
      bus.cfg_data = d;
      tick();
      bus.cfg_we   = 1'b0;
      model_tbl[a] = d;
   endtask

   task automatic load_tree();
      cfg_write(0,  mk(0, 1, 83, 1, 2));
      cfg_write(1,  mk(1, 0, 0, 0, 0));
      cfg_write(2,  mk(0, 0, 53, 3, 4));
      cfg_write(3,  mk(0, 1, 158, 5, 6));
      cfg_write(5,  mk(1, 0, 1, 0, 0));
      cfg_write(6,  mk(1, 0, 2, 0, 0));
      cfg_write(4,  mk(0, 1, 155, 7, 8));
      cfg_write(7,  mk(0, 2, 99, 9, 10));
      cfg_write(9,  mk(1, 0, 2, 0, 0));
      cfg_write(10, mk(1, 0, 1, 0, 0));
      cfg_write(8,  mk(1, 0, 2, 0, 0));
   endtask

   // Present a sample for one edge, optionally with a table write on the
   // same edge; in_feat is scrambled right after acceptance.
   task automatic accept(input string nm, input logic [31:0] f, input bit wr,
                         input int wa, input logic [18:0] wd);
      chk({nm, "_in_ready"}, int'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_feat  = f;
      if (wr) begin
         bus.cfg_we   = 1'b1;
         bus.cfg_addr = 4'(wa);
         bus.cfg_data = wd;
      end
      tick();
      bus.in_valid = 1'b0;
      bus.cfg_we   = 1'b0;
      bus.in_feat  = $urandom();
      if (wr) model_tbl[wa] = wd;
   endtask

   // Wait for the result, hold it for 'hold' cycles (optionally poking the
   // table while busy), then take it with in_valid also high on that edge.
   task automatic collect(input string nm, input int ec, input int ee,
                          input int elat, input int hold, input bit poke);
      int n = 0;
      bit seen = 1'b0;
      while (n < 40) begin
         if (bus.out_valid) begin
            seen = 1'b1;
            break;
         end
         tick();
         n++;
      end
      chk({nm, "_latency"}, seen ? n + 1 : -1, elat);
      if (!seen) begin
         do_reset();
         return;
      end
      chk({nm, "_cls"}, int'(bus.cls), ec);
      chk({nm, "_err"}, int'(bus.err), ee);
      chk({nm, "_busy_in_ready"}, int'(bus.in_ready), 0);
      for (int i = 0; i < hold; i++) begin
         if (poke) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = 4'd9;
            bus.cfg_data = 19'h40000;
         end
         tick();
         bus.cfg_we = 1'b0;
         chk({nm, "_hold_cls"}, int'(bus.cls), ec);
         chk({nm, "_hold_valid"}, int'(bus.out_valid), 1);
         chk({nm, "_hold_in_ready"}, int'(bus.in_ready), 0);
         if (poke) chk({nm, "_hold_cfg_ready"}, int'(bus.cfg_ready), 0);
      end
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_feat   = $urandom();
      tick();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      chk({nm, "_taken_valid"}, int'(bus.out_valid), 0);
      chk({nm, "_no_accept_on_take"}, int'(bus.in_ready), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, e, l;
      bit ok;

      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_data  = '0;
      bus.in_valid  = 1'b0;
      bus.in_feat   = '0;
      bus.out_ready = 1'b0;

      vecs[0] = '{"v1_pl50",        32'h0000_3200, 0, 0, 3};
      vecs[1] = '{"v2_pl100_pw40",  32'h0000_6428, 1, 0, 5};
      vecs[2] = '{"v3_sw90",        32'h005A_643C, 2, 0, 6};
      vecs[3] = '{"sw99_right",     32'h0063_643C, 1, 0, 6};
      vecs[4] = '{"pl160_node6",    32'h0000_A028, 2, 0, 5};
      vecs[5] = '{"pl155_node8",    32'h0000_9B3C, 2, 0, 5};
      vecs[6] = '{"equal_thr",      32'h0000_5335, 2, 0, 6};
      vecs[7] = '{"pl82_max_other", 32'hFFFF_52FF, 0, 0, 3};

      do_reset();
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_in_ready",  int'(bus.in_ready), 1);
      chk("rst_cfg_ready", int'(bus.cfg_ready), 1);
      chk("rst_cls",       int'(bus.cls), 0);
      chk("rst_err",       int'(bus.err), 0);

      // Empty table: node 0 is a class-0 leaf.
      accept("empty", 32'h1234_5678, 1'b0, 0, '0);
      collect("empty", 0, 0, 2, 0, 1'b0);

      load_tree();
      foreach (vecs[i]) begin
         accept(vecs[i].name, vecs[i].feat, 1'b0, 0, '0);
         collect(vecs[i].name, vecs[i].cls, vecs[i].err, vecs[i].lat, i % 3, 1'b0);
      end

      // Long hold in DONE with write attempts to node 9.
      accept("v5", 32'h005A_643C, 1'b0, 0, '0);
      collect("v5", 2, 0, 6, 10, 1'b1);
      accept("v5_recheck", 32'h005A_643C, 1'b0, 0, '0);
      collect("v5_recheck", 2, 0, 6, 0, 1'b0);

      // Write node 1 on the acceptance edge; the walk must see it.
      accept("same_edge", 32'h0000_3200, 1'b1, 1, mk(1, 0, 3, 0, 0));
      collect("same_edge", 3, 0, 3, 0, 1'b0);

      // Reset in the middle of a walk.
      accept("v6", 32'h005A_643C, 1'b0, 0, '0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("v6_valid_in_rst", int'(bus.out_valid), 0);
      rst = 1'b0;
      model_reset();
      chk("v6_in_ready_after_rst", int'(bus.in_ready), 1);
      ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (bus.out_valid) ok = 1'b0;
         tick();
      end
      chk("v6_no_result", int'(ok), 1);
      accept("v6_after", 32'h005A_643C, 1'b0, 0, '0);
      collect("v6_after", 0, 0, 2, 0, 1'b0);

      // Self-loop on node 0 runs into the step guard.
      cfg_write(0, mk(0, 0, 0, 0, 0));
      accept("v4_loop", 32'hFFFF_FFFF, 1'b0, 0, '0);
      collect("v4_loop", 0, 1, MAXS + 2, 1, 1'b0);

      // Random tables and samples against the reference walk.
      for (int t = 0; t < 4; t++) begin
         for (int a = 0; a < 16; a++) begin
            cfg_write(a, mk(($urandom_range(2) == 0) ? 1 : 0, $urandom_range(3),
                            $urandom_range(255), $urandom_range(15),
                            $urandom_range(15)));
         end
         for (int s = 0; s < 10; s++) begin
            logic [31:0] f;
            f = $urandom();
            model_walk(f, c, e, l);
            accept($sformatf("rnd%0d_%0d", t, s), f, 1'b0, 0, '0);
            collect($sformatf("rnd%0d_%0d", t, s), c, e, l,
                    $urandom_range(2), 1'b0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dt_node_walker.md
DT_NODE_WALKER -- requirements
Module: dt_node_walker

Interface
REQ-001 Parameters: N = 8, feature and threshold width; C = 2, class width; F = 4, feature count; NODES = 16, node-table depth; MAX_STEPS = NODES, walk-length guard.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cfg_we  in  1  node-table write strobe.
REQ-005 cfg_addr  in  4  node index.
REQ-006 cfg_data  in  19  node word: {leaf[18], feat[17:16], thr[15:8], left[7:4], right[3:0]}; for a leaf, class = thr[C-1:0].
REQ-007 cfg_ready  out  1  high when the table is writable, i.e. state IDLE.
REQ-008 in_valid  in  1  sample valid.
REQ-009 in_ready  out  1  sample accept, high only in IDLE.
REQ-010 in_feat  in  F*N  features packed {SEPAL_LENGTH, SEPAL_WIDTH, PETAL_LENGTH, PETAL_WIDTH}; feat index 0 = PETAL_WIDTH (LSBs), index 3 = SEPAL_LENGTH.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  result accept.
REQ-013 cls  out  C  class result.
REQ-014 err  out  1  walk exceeded MAX_STEPS without reaching a leaf.

Function
REQ-015 The FSM SHALL have states IDLE, WALK and DONE.
REQ-016 In IDLE, in_valid&&in_ready SHALL register in_feat, set ptr=0 and steps=0, and go to WALK.
REQ-017 In WALK, each cycle SHALL read node[ptr] combinationally.
  - Leaf node: latch cls = thr[C-1:0], err = 0, go to DONE.
  - Internal node: ptr = (feature[feat] < thr) ? left : right, using an unsigned compare; the true branch goes left.
REQ-018 A walk visiting k internal nodes SHALL assert out_valid exactly k+2 cycles after the acceptance edge.
REQ-019 If steps reaches MAX_STEPS while in WALK without a leaf, the block SHALL go to DONE with cls = 0 and err = 1.
REQ-020 In DONE, out_valid SHALL be 1; cls and err SHALL be held stable until out_valid&&out_ready, then the FSM returns to IDLE.
REQ-021 The block SHALL accept no new sample on the cycle the result is taken; the next acceptance happens at the earliest one cycle later.
REQ-022 cfg_we SHALL write node[cfg_addr] only when cfg_ready = 1; writes while busy SHALL be ignored, with no effect on the table or the in-flight walk.
REQ-023 If cfg_we and in_valid are both asserted in IDLE, both SHALL take effect on the same edge, and the walk SHALL see the new table contents.
REQ-024 in_feat changes after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-025 While rst = 1, the block SHALL go to IDLE with out_valid = 0, cls = 0, err = 0, ptr = 0 and steps = 0.
REQ-026 While rst = 1, every table entry SHALL be set to a leaf with class 0, i.e. word 19'h40000.
REQ-027 rst asserted mid-WALK or in DONE SHALL abort the operation, discard the result and clear the table; in_ready = 1 on the first cycle after rst is released.

Structure
REQ-028 Package dt_walker_pkg SHALL hold N, C, F, NODES, the node_t packed struct (leaf, feat, thr, left, right), the state_t enum, and the RESET_NODE constant.
REQ-029 Sub-module dt_node_table SHALL implement the NODES x 19 register file: synchronous write port, combinational read port, synchronous reset to RESET_NODE.

Verification
Table load for V1 to V3:
  - node0 {0,PL=1,83,L1,R2}
  - node1 leaf cls0
  - node2 {0,PW=0,53,L3,R4}
  - node3 {0,PL,158,L5,R6}
  - node5 leaf cls1
  - node6 leaf cls2
  - node4 {0,PL,155,L7,R8}
  - node7 {0,SW=2,99,L9,R10}
  - node9 leaf cls2
  - node10 leaf cls1
  - node8 leaf cls2
REQ-030 V1: PL=50 -> cls=0, err=0, out_valid 3 cycles after accept.
REQ-031 V2: PL=100, PW=40 -> cls=1 at accept+5. V3: PL=100, PW=60, SW=90 -> cls=2 at accept+6.
REQ-032 V4: node0 = {0,feat0,thr0,L0,R0} self-loop -> after MAX_STEPS, cls=0, err=1, out_valid=1.
REQ-033 V5: hold out_ready = 0 for 10 cycles in DONE with cfg_we pulsed -> cls stable, table unchanged, in_ready = 0 throughout.
REQ-034 V6: assert rst during WALK -> out_valid never asserted; the following sample returns cls=0 (reset table); in_ready = 1 the cycle after release.
